// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - request/response handshake bundle for the execute unit
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    // Producer/consumer side: issues requests and takes results
    modport master (
        output in_valid, alu_ctrl, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    // Execute unit side
    modport slave (
        input  in_valid, alu_ctrl, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle ALU execute unit with iterative one-bit shifter
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    alu_exec_unit_if.slave   bus
);
    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic [WIDTH-1:0]   acc_q;
    logic [SHAMT_W-1:0] count_q;
    logic [3:0]         ctrl_q;

    logic [WIDTH-1:0]   alu_res_d;
    logic [WIDTH-1:0]   acc_d;
    logic               req_is_shift;
    logic [SHAMT_W-1:0] req_shamt;

    assign req_is_shift = (bus.alu_ctrl == OP_SLL) || (bus.alu_ctrl == OP_SRL) ||
                          (bus.alu_ctrl == OP_SRA);
    assign req_shamt    = bus.op_b[SHAMT_W-1:0];

    // Single-cycle datapath on the incoming operands; unknown codes fall back to ADD
    always_comb begin
        alu_res_d = bus.op_a + bus.op_b;
        case (bus.alu_ctrl)
            OP_AND:  alu_res_d = bus.op_a & bus.op_b;
            OP_OR:   alu_res_d = bus.op_a | bus.op_b;
            OP_SUB:  alu_res_d = bus.op_a - bus.op_b;
            OP_SLT:  alu_res_d = {{(WIDTH-1){1'b0}},
                                  ($signed(bus.op_a) < $signed(bus.op_b))};
            default: alu_res_d = bus.op_a + bus.op_b;
        endcase
    end

    // One-bit shift step of the accumulator using the latched opcode
    always_comb begin
        acc_d = acc_q;
        case (ctrl_q)
            OP_SLL:  acc_d = {acc_q[WIDTH-2:0], 1'b0};
            OP_SRL:  acc_d = {1'b0, acc_q[WIDTH-1:1]};
            OP_SRA:  acc_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            default: acc_d = acc_q;
        endcase
    end

    // Control FSM with registered handshake outputs, result and zero flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            acc_q       <= '0;
            count_q     <= '0;
            ctrl_q      <= OP_AND;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        ctrl_q     <= bus.alu_ctrl;
                        in_ready_q <= 1'b0;
                        if (req_is_shift && (req_shamt != '0)) begin
                            acc_q   <= bus.op_a;
                            count_q <= req_shamt;
                            state_q <= SHIFT;
                        end else if (req_is_shift) begin
                            result_q    <= bus.op_a;
                            zero_q      <= (bus.op_a == '0);
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            result_q    <= alu_res_d;
                            zero_q      <= (alu_res_d == '0);
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    acc_q   <= acc_d;
                    count_q <= count_q - 1'b1;
                    if (count_q == SHAMT_W'(1)) begin
                        result_q    <= acc_d;
                        zero_q      <= (acc_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
endmodule
